// File: rtl/mac_unpack_div_pkg.sv
// rtl/mac_unpack_div_pkg.sv - shared widths and state encoding for the multiply-add unpacker
// Purpose: operand widths, iteration counter width and FSM state type.
// Ports: none (package).
package mac_unpack_div_pkg;

    localparam int IN     = 8;
    localparam int REGOUT = 16;
    localparam int CNTW   = $clog2(REGOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mac_unpack_div_if.sv
// rtl/mac_unpack_div_if.sv - request/result bundle between a requester and the unpacker
// Purpose: groups the start/operand request and the busy/done/result response.
// Ports: start, D, B, C (requester -> unpacker); busy, done, err, Q, R (unpacker -> requester).
interface mac_unpack_div_if;
    import mac_unpack_div_pkg::*;

    // Bit 0 is the MSB of every bus.
    logic              start;
    logic [0:REGOUT-1] D;
    logic [0:IN-1]     B;
    logic [0:IN-1]     C;
    logic              busy;
    logic              done;
    logic              err;
    logic [0:REGOUT-1] Q;
    logic [0:IN-1]     R;

    modport master (
        output start, D, B, C,
        input  busy, done, err, Q, R
    );

    modport slave (
        input  start, D, B, C,
        output busy, done, err, Q, R
    );

endinterface

// File: rtl/mac_unpack_div_div_step.sv
// rtl/mac_unpack_div_div_step.sv - one combinational restoring-division step
// Purpose: shift the partial remainder left, bring in one dividend bit, trial-subtract B.
// Ports: rem_in (partial remainder), bit_in (next dividend bit), b (divisor),
//        rem_out (updated remainder), q_bit (quotient bit for this step).
module mac_unpack_div_div_step
    import mac_unpack_div_pkg::*;
(
    input  logic [0:IN]   rem_in,
    input  logic          bit_in,
    input  logic [0:IN-1] b,
    output logic [0:IN]   rem_out,
    output logic          q_bit
);

    logic [0:IN] shifted;

    // rem_in is always < b, so its top bit is zero and can be dropped by the shift.
    always_comb begin
        shifted = {rem_in[1:IN], bit_in};
        q_bit   = 1'b0;
        rem_out = shifted;
        if (shifted >= {1'b0, b}) begin
            q_bit   = 1'b1;
            rem_out = shifted - {1'b0, b};
        end
    end

endmodule

// File: rtl/mac_unpack_div.sv
// rtl/mac_unpack_div.sv - recovers A = (D - C) / B and (D - C) mod B with an iterative divider
// Purpose: start/busy/done sequencer around a single reused restoring step.
// Ports: clk (rising-edge clock), rst (async active-high reset),
//        bus (slave side: start/D/B/C in, busy/done/err/Q/R out).
module mac_unpack_div
    import mac_unpack_div_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mac_unpack_div_if.slave bus
);

    state_t            state, state_nx;
    logic [0:REGOUT-1] d_lat;
    logic [0:IN-1]     b_lat;
    logic [0:IN-1]     c_lat;
    logic [0:REGOUT-1] dividend;
    logic [0:IN]       rem;
    logic [0:REGOUT-1] q_work;
    logic [CNTW-1:0]   cnt;
    logic              err_int;
    logic [0:IN-1]     err_rem;
    logic              busy_c;
    logic              done_r;
    logic              err_r;
    logic [0:REGOUT-1] q_r;
    logic [0:IN-1]     r_r;
    logic [0:REGOUT]   n;
    logic [0:IN]       step_rem;
    logic              step_q;

    // Bit 0 of n is the borrow of D - C.
    assign n = {1'b0, d_lat} - {{(REGOUT + 1 - IN){1'b0}}, c_lat};

    mac_unpack_div_div_step u_step (
        .rem_in  (rem),
        .bit_in  (dividend[0]),
        .b       (b_lat),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_nx = state;
        busy_c   = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nx = SUB;
            SUB: begin
                busy_c = 1'b1;
                if (n[0] || (b_lat == '0)) state_nx = DONE;
                else                       state_nx = DIV;
            end
            DIV: begin
                busy_c = 1'b1;
                if (cnt == '0) state_nx = DONE;
            end
            DONE: state_nx = bus.start ? SUB : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            d_lat    <= '0;
            b_lat    <= '0;
            c_lat    <= '0;
            dividend <= '0;
            rem      <= '0;
            q_work   <= '0;
            cnt      <= '0;
            err_int  <= 1'b0;
            err_rem  <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            q_r      <= '0;
            r_r      <= '0;
        end else begin
            state  <= state_nx;
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // Results publish on the edge leaving DONE, so done is seen one cycle later.
                    if (state == DONE) begin
                        done_r <= 1'b1;
                        err_r  <= err_int;
                        q_r    <= err_int ? '1 : q_work;
                        r_r    <= err_int ? err_rem : rem[1:IN];
                    end
                    if (bus.start) begin
                        d_lat   <= bus.D;
                        b_lat   <= bus.B;
                        c_lat   <= bus.C;
                        err_int <= 1'b0;
                    end
                end
                SUB: begin
                    if (n[0]) begin
                        err_int <= 1'b1;
                        err_rem <= '0;
                    end else if (b_lat == '0) begin
                        err_int <= 1'b1;
                        err_rem <= d_lat[REGOUT-IN:REGOUT-1];
                    end else begin
                        dividend <= n[1:REGOUT];
                        rem      <= '0;
                        q_work   <= '0;
                        cnt      <= CNTW'(REGOUT - 1);
                    end
                end
                DIV: begin
                    rem      <= step_rem;
                    q_work   <= {q_work[1:REGOUT-1], step_q};
                    dividend <= {dividend[1:REGOUT-1], 1'b0};
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_r;
    assign bus.err  = err_r;
    assign bus.Q    = q_r;
    assign bus.R    = r_r;

endmodule

// File: tb/tb_mac_unpack_div.sv
// tb/tb_mac_unpack_div.sv - self-checking bench for the multiply-add unpacker
module tb_mac_unpack_div;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    mac_unpack_div_if bus ();

    mac_unpack_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [15:0] d;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [15:0] q;
        logic [7:0]  r;
        logic        e;
        int          lat;
    } vec_t;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Waits for the done pulse; returns the cycle stamp or -1 on timeout.
    task automatic wait_done(output int t);
        t = -1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic start_op(input logic [15:0] d, input logic [7:0] b, input logic [7:0] c,
                            output int t0);
        @(negedge clk);
        bus.D     = d;
        bus.B     = b;
        bus.C     = c;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        t0        = cyc;
        bus.start = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [15:0] d, input logic [7:0] b,
                             input logic [7:0] c, input logic [15:0] eq, input logic [7:0] er,
                             input logic ee, input int elat);
        int t0, t1;
        start_op(d, b, c, t0);
        wait_done(t1);
        check({tag, " latency"}, (t1 < 0) ? -1 : t1 - t0, elat);
        check({tag, " Q"}, bus.Q, eq);
        check({tag, " R"}, bus.R, er);
        check({tag, " err"}, bus.err, ee);
    endtask

    // Reference: plain integer division on the unpacked difference.
    task automatic model(input logic [15:0] d, input logic [7:0] b, input logic [7:0] c,
                         output logic [15:0] q, output logic [7:0] r, output logic e,
                         output int lat);
        int diff;
        diff = int'(d) - int'(c);
        if (diff < 0) begin
            q = 16'hFFFF; r = 8'h00; e = 1'b1; lat = 2;
        end else if (b == 8'd0) begin
            q = 16'hFFFF; r = d[7:0]; e = 1'b1; lat = 2;
        end else begin
            q = 16'(diff / int'(b)); r = 8'(diff % int'(b)); e = 1'b0; lat = 18;
        end
    endtask

    vec_t vecs[9];

    initial begin
        int t0, t1;
        bit saw_done;
        logic [15:0] d, eq;
        logic [7:0]  b, c, er;
        logic        ee;
        int          elat;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{16'd100,   8'd11,  8'd1,   16'd9,      8'd0,   1'b0, 18};
        vecs[1] = '{16'd1000,  8'd13,  8'd7,   16'd76,     8'd5,   1'b0, 18};
        vecs[2] = '{16'd500,   8'd0,   8'd3,   16'hFFFF,   8'hF4,  1'b1, 2};
        vecs[3] = '{16'd5,     8'd4,   8'd9,   16'hFFFF,   8'd0,   1'b1, 2};
        vecs[4] = '{16'd65535, 8'd1,   8'd0,   16'd65535,  8'd0,   1'b0, 18};
        vecs[5] = '{16'd7,     8'd7,   8'd7,   16'd0,      8'd0,   1'b0, 18};
        vecs[6] = '{16'd0,     8'd0,   8'd0,   16'hFFFF,   8'd0,   1'b1, 2};
        vecs[7] = '{16'd300,   8'd255, 8'd255, 16'd0,      8'd45,  1'b0, 18};
        vecs[8] = '{16'd65535, 8'd255, 8'd255, 16'd256,    8'd0,   1'b0, 18};

        bus.start = 1'b0;
        bus.D     = '0;
        bus.B     = '0;
        bus.C     = '0;
        rst       = 1'b1;
        #12;
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset err",  bus.err,  0);
        check("reset Q",    bus.Q,    0);
        check("reset R",    bus.R,    0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_check($sformatf("vec%0d", i), vecs[i].d, vecs[i].b, vecs[i].c,
                      vecs[i].q, vecs[i].r, vecs[i].e, vecs[i].lat);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done pulse width", i), bus.done, 0);
        end

        // Start while busy is ignored; start during the done cycle is accepted from IDLE.
        start_op(16'd100, 8'd11, 8'd1, t0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.D     = 16'd0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy during DIV", bus.busy, 1);
        wait_done(t1);
        check("ignore latency", (t1 < 0) ? -1 : t1 - t0, 18);
        check("ignore Q", bus.Q, 9);
        check("ignore R", bus.R, 0);
        bus.D     = 16'd255;
        bus.B     = 8'd255;
        bus.C     = 8'd0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(t1);
        check("b2b latency", (t1 < 0) ? -1 : t1 - t0, 37);
        check("b2b Q", bus.Q, 1);
        check("b2b R", bus.R, 0);
        check("b2b err", bus.err, 0);

        // Asynchronous reset in the middle of DIV.
        start_op(16'd100, 8'd11, 8'd1, t0);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort busy", bus.busy, 0);
        check("abort done", bus.done, 0);
        check("abort Q",    bus.Q,    0);
        check("abort R",    bus.R,    0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        check("no done after abort", saw_done, 0);
        run_check("post-reset", 16'd65535, 8'd255, 8'd0, 16'd257, 8'd0, 1'b0, 18);

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 30; i++) begin
            int mode;
            mode = $urandom_range(0, 3);
            d = 16'($urandom);
            c = 8'($urandom);
            b = (mode == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (mode == 1) d = 16'($urandom_range(0, 255));
            model(d, b, c, eq, er, ee, elat);
            run_check($sformatf("rnd%0d", i), d, b, c, eq, er, ee, elat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
